note_scheduler: RTL
===================

# note_scheduler

Serializes a multi-hot batch of active notes into a stream of one-hot note codes, one per accepted handshake, in ascending bit order. It sits between the game datapath, which may raise several of the 30 notes (5 bars × 6 positions) in one update, and the single one-hot-to-coordinate converter and draw/strike unit downstream, which service one note at a time. It is the arbiter that shares that converter among all simultaneously active notes.

## Interface
- NUM_NOTES, 30: number of note bits handled. Fixed at 30 for the 5×6 grid. Output bits NUM_NOTES..31 are always 0.
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- note_bits  input  30  multi-hot batch of active notes; bit k maps to one-hot code 1<<k.
- note_valid  input  1  single-cycle load strobe for note_bits.
- note_out  output  32  one-hot code of the note currently offered; 0 when none.
- out_valid  output  1  note_out holds a valid note.
- out_ready  input  1  downstream accepts note_out this cycle.
- busy  output  1  high in ISSUE.
- done  output  1  one-cycle pulse when a batch is fully issued.
- issued_cnt  output  5  number of notes handed off in the current batch.
- overflow  output  1  sticky: a load was dropped while busy.

## Operation
- Registers: pending[29:0], state, issued_cnt, overflow.
- States: IDLE, ISSUE, DONE.
- IDLE or DONE, note_valid=1:
  - pending <= note_bits; issued_cnt <= 0; overflow <= 0.
  - Next state is ISSUE if note_bits≠0, otherwise DONE.
- IDLE or DONE, note_valid=0: go to IDLE (DONE always lasts exactly one cycle).
- ISSUE:
  - out_valid=1.
  - note_out = lowest set bit of pending, zero-extended to 32 bits.
  - On a handshake (out_valid & out_ready): clear that bit; issued_cnt += 1.
  - If the remaining pending is 0, go to DONE. Otherwise stay in ISSUE.
  - With out_ready=0, note_out and pending hold.
- done=1 only in DONE. out_valid=0 and note_out=0 outside ISSUE.
- note_valid in ISSUE: handled as described under Configuration.
- issued_cnt saturates at 30 and holds its value through DONE and IDLE until the next accepted load.

## Timing
- Reset (asynchronous, immediate): state=IDLE, pending=0, note_out=0, out_valid=0, busy=0, done=0, issued_cnt=0, overflow=0. Reset mid-batch discards pending and suppresses the done pulse.
- Load latency: note_valid at edge N gives out_valid=1 with the first note in cycle N+1.
- Throughput: one note per cycle while out_ready is held high. The next note is presented in the cycle after each handshake edge.
- Batch of K notes with out_ready tied high:
  - Handshakes occur in cycles N+1..N+K.
  - done=1 in cycle N+K+1.
  - IDLE from cycle N+K+2, or ISSUE again if a new load is accepted in the DONE cycle.
- Empty load: done=1 in cycle N+1; no out_valid.
- Ordering: strictly ascending bit index within the pending set.
- All outputs are derived from registers only; no combinational path from any input to any output.

## Configuration
- NOTE_SCHED_MERGE_EN defined:
  - note_valid in ISSUE: pending <= (pending & ~handshaken_bit) | note_bits. A new bit wins over a same-cycle clear of that bit.
  - issued_cnt is not reset; overflow is never set.
  - The batch continues until the merged pending set is empty.
- NOTE_SCHED_MERGE_EN undefined:
  - note_valid in ISSUE is ignored and sets overflow=1. overflow stays set until the next accepted load or reset.
  - The current batch is unaffected.

## Test plan
- Reset, then note_valid with note_bits=30'h0000_0025, out_ready=1 -> note_out 32'd1, 32'd4, 32'd32 on three consecutive cycles; done pulse next cycle; issued_cnt=3.
- note_bits=30'h2000_0001, out_ready=0 for 5 cycles then 1 -> note_out holds 32'd1 for 5 cycles, then 32'd1 and 32'd536870912 are handed off; issued_cnt=2.
- note_valid with note_bits=0 -> done=1 one cycle after the load; out_valid never asserts; issued_cnt=0.
- Without the macro: load 30'h3 at edge N, then note_valid with 30'h100 at N+1 -> issue 32'd1, 32'd2 only; overflow=1 after edge N+1. With the macro, same stimulus -> issue 32'd1, 32'd2, 32'd256; overflow=0.
- reset asserted mid-batch with 30'h3F loaded after the second handshake -> out_valid and note_out drop to 0 immediately; no done pulse; after release, a load of 30'h40 yields 32'd64.
- Load 30'h3FFF_FFFF with out_ready=1 -> 30 consecutive one-hot codes, 1 through 2^29; issued_cnt=30; done one cycle later.

Source files
------------

// File: rtl/note_scheduler.sv
// note_scheduler: serializes a multi-hot batch of 30 notes into one-hot codes, lowest bit first.
// Optional feature macro NOTE_SCHED_MERGE_EN: loads during ISSUE merge into the pending set.
module note_scheduler (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] note_bits,
  input  logic        note_valid,
  output logic [31:0] note_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic [4:0]  issued_cnt,
  output logic        overflow
);

  localparam logic [4:0] CNT_MAX = 5'd30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [29:0] pending_r;
  logic [29:0] pending_s;
  logic [29:0] low_bit_s;
  logic [29:0] hs_bit_s;
  logic [29:0] remain_s;
  logic [29:0] next_low_s;
  logic [4:0]  cnt_s;
  logic        ovf_s;

  // Next-state and next-register computation for the issue sequencer.
  always_comb begin
    state_s    = state_r;
    pending_s  = pending_r;
    cnt_s      = issued_cnt;
    ovf_s      = overflow;
    low_bit_s  = pending_r & (~pending_r + 30'd1);
    hs_bit_s   = 30'd0;
    remain_s   = pending_r;
    case (state_r)
      IDLE, DONE: begin
        if (note_valid) begin
          pending_s = note_bits;
          cnt_s     = 5'd0;
          ovf_s     = 1'b0;
          state_s   = (note_bits != 30'd0) ? ISSUE : DONE;
        end else begin
          state_s   = IDLE;
        end
      end
      ISSUE: begin
        if (out_ready) begin
          hs_bit_s = low_bit_s;
          cnt_s    = (issued_cnt >= CNT_MAX) ? CNT_MAX : issued_cnt + 5'd1;
        end else begin
          hs_bit_s = 30'd0;
        end
        remain_s = pending_r & ~hs_bit_s;
`ifdef NOTE_SCHED_MERGE_EN
        // OR after the clear so a freshly loaded bit survives a same-cycle handshake.
        if (note_valid) begin
          remain_s = remain_s | note_bits;
        end else begin
          remain_s = remain_s;
        end
`else
        if (note_valid) begin
          ovf_s = 1'b1;
        end else begin
          ovf_s = overflow;
        end
`endif
        pending_s = remain_s;
        state_s   = (remain_s == 30'd0) ? DONE : ISSUE;
      end
      default: begin
        state_s   = IDLE;
        pending_s = 30'd0;
      end
    endcase
    next_low_s = pending_s & (~pending_s + 30'd1);
  end

  // State, pending set and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      pending_r  <= 30'd0;
      issued_cnt <= 5'd0;
      overflow   <= 1'b0;
      note_out   <= 32'd0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      pending_r  <= pending_s;
      issued_cnt <= cnt_s;
      overflow   <= ovf_s;
      note_out   <= (state_s == ISSUE) ? {2'b00, next_low_s} : 32'd0;
      out_valid  <= (state_s == ISSUE);
      busy       <= (state_s == ISSUE);
      done       <= (state_s == DONE);
    end
  end

endmodule
